acf_normalise_sequencer: RTL and testbench
==========================================

Name: acf_normalise_sequencer

Overview:
Sequences normalisation of one block of integer autocorrelation sums into floating-point coefficients ACF[k]/ACF[0], k = 0..LAGS. It reads the integer sums through an address/data port and time-shares one int-to-float converter and one fp divider. It emits the coefficients as an indexed stream. It sits between the autocorrelation accumulator and the LPC coefficient stage, and replaces ad-hoc process counters in the datapath.

Parameters:
LAGS, 12, highest lag index; LAGS+1 coefficients per block
ACF_W, 43, width of signed integer ACF sums
CONV_DELAY, 7, converter latency in clk_en-enabled cycles
DIV_DELAY, 14, divider latency in clk_en-enabled cycles

Ports:
iClock  in  1  clock
iReset  in  1  reset
iStart  in  1  request normalisation of the current sums (pulse)
oACFAddr  out  4  index of integer sum being read
iACFData  in  ACF_W  signed sum at oACFAddr, combinational read
oConvEn  out  1  converter clk_en
oConvData  out  64  converter input, sign-extended iACFData
iConvResult  in  32  converter output (IEEE single)
oDivEn  out  1  divider clk_en
oNumerator  out  32  divider dataa
oDenominator  out  32  divider datab
iDivResult  in  32  divider output
oCoeffValid  out  1  oCoeff/oCoeffIndex valid this cycle
oCoeffIndex  out  4  lag index k of oCoeff
oCoeff  out  32  ACF[k]/ACF[0], IEEE single
oBusy  out  1  sequence in progress
oDone  out  1  one-cycle pulse after last coefficient
oOverrun  out  1  one-cycle pulse: iStart rejected while busy

Behaviour:
- Reset: synchronous, active-high iReset; clock iClock. All outputs are 0 on reset except oDenominator, which resets to 0x3F800000. Reset mid-sequence aborts immediately. No stale oCoeffValid follows reset.
- States: IDLE, RUN, DONE.
- IDLE -> RUN when iStart=1; the accepting cycle is T.
- RUN: oBusy=1; oConvEn=oDivEn=1 for the whole of RUN. Pipelines never stall, so latencies are exact.
- RUN lasts until the last coefficient is emitted, then -> DONE for one cycle (oDone=1, oBusy=1), then -> IDLE.
- Read schedule: oACFAddr = k during cycle T+1+k, k = 0..LAGS. oACFAddr = 0 outside that window.
- Converter input: oConvData registered, sign-extended; valid at T+2+k.
- Converter output for k appears at T+2+k+CONV_DELAY.
- Divider inputs are registered from the converter output, valid at T+3+k+CONV_DELAY:
  - k=0: numerator = denominator = converted ACF0. The denominator is then held for the rest of the block.
  - k>0: numerator = converted ACF[k].
- Output: oCoeff registered from iDivResult. oCoeffValid=1, oCoeffIndex=k at T+4+k+CONV_DELAY+DIV_DELAY; coefficients are consecutive, one per cycle.
- Done: oDone at T+5+LAGS+CONV_DELAY+DIV_DELAY (defaults: last coeff T+37, oDone T+38).
- Tracking: valid/index tagging uses a tag delay line aligned to the pipeline depth, not free-running compare constants.
- oCoeff/oCoeffIndex hold their last values when oCoeffValid=0.
- Zero ACF0: if iACFData==0 at address 0, the block latches a zero flag. Timing is unchanged, but emitted values are overridden: k=0 -> 0x3F800000, k>0 -> 0x00000000. Divider output is ignored; no NaN/Inf ever leaves the block.
- iStart while RUN or DONE: ignored, oOverrun pulses the same cycle. iStart in the cycle after DONE (IDLE) is accepted normally.
- Negative sums are converted signed; no saturation is needed, since 43 bits fit in 64.

Decomposition:
- Shared package acf_pkg:
  - constants LAGS, ACF_W, CONV_DELAY, DIV_DELAY
  - FP_ONE = 32'h3F800000
  - type for the 4-bit lag index
- Sub-module acf_tag_delay: parameterised depth shift register carrying {valid, index, zero_flag}, reset to zero. Used with depth CONV_DELAY+DIV_DELAY+2 to align tags with oCoeff.

Test Plan:
- Ramp: ACF[k] = 4096-256k (ACF0=4096), iStart at T, bench models ideal converter/divider with default delays -> 13 coeffs at T+25..T+37, indices 0..12, values 1.0, 0.9375, ..., 0.25, oDone at T+38 only.
- Zero ACF0: all sums 0 -> index0 = 0x3F800000, indices 1..12 = 0x00000000, same timing; the divider model's NaN never appears on oCoeff.
- Negative lag: ACF0=1000, ACF1=-500 -> oCoeff[1] = 0xBF000000 (-0.5); oConvData for k=1 = 64'hFFFF_FFFF_FFFF_FE0C.
- Start while busy: iStart at T and T+10 -> oOverrun=1 at T+10, exactly one sequence, oDone once. Back-to-back: iStart at T+39 accepted, second oDone at T+77.
- Reset mid-run: iReset at T+20 for 1 cycle -> from T+21 all outputs at reset values, no oCoeffValid or oDone. A fresh iStart afterwards completes with correct values.
- Enables: oConvEn/oDivEn high exactly T+1..T+38, low in IDLE; oACFAddr sweeps 0..12 at T+1..T+13.

Source files
------------

// File: rtl/acf_normalise_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// acf_pkg
// Shared constants and types for the ACF normalisation sequencer.
//   LAGS        highest lag index (LAGS+1 coefficients per block)
//   ACF_W       width of the signed integer autocorrelation sums
//   CONV_DELAY  int-to-float converter latency in enabled cycles
//   DIV_DELAY   fp divider latency in enabled cycles
//   FP_ONE      IEEE single 1.0
// -----------------------------------------------------------------------------
package acf_pkg;

   localparam int LAGS       = 12;
   localparam int ACF_W      = 43;
   localparam int CONV_DELAY = 7;
   localparam int DIV_DELAY  = 14;

   localparam logic [31:0] FP_ONE = 32'h3F80_0000;

   // Tag line depth: read cycle -> cycle the divider result is on iDivResult.
   localparam int TAG_DEPTH = CONV_DELAY + DIV_DELAY + 2;

   typedef logic [3:0] lag_idx_t;

   localparam lag_idx_t LAST_IDX = lag_idx_t'(LAGS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } seq_state_t;

   // Tag travelling alongside each sample through converter and divider.
   typedef struct packed {
      logic     valid;
      lag_idx_t index;
      logic     zero;
   } acf_tag_t;

   // Sign-extend a raw ACF sum to the 64-bit converter input.
   function automatic logic [63:0] sext_acf(input logic [ACF_W-1:0] v);
      return {{(64 - ACF_W){v[ACF_W-1]}}, v};
   endfunction

endpackage

// File: rtl/acf_normalise_sequencer_if.sv
// -----------------------------------------------------------------------------
// acf_normalise_sequencer_if
// Control handshake and coefficient stream of the ACF normalisation sequencer.
//   iStart       request normalisation of the current sums (pulse)
//   oBusy        sequence in progress
//   oDone        one-cycle pulse after the last coefficient
//   oOverrun     one-cycle pulse: iStart rejected while busy
//   oCoeffValid  oCoeff/oCoeffIndex valid this cycle
//   oCoeffIndex  lag index k of oCoeff
//   oCoeff       ACF[k]/ACF[0], IEEE single
// master: the sequencer; slave: the block that starts it and takes the stream.
// -----------------------------------------------------------------------------
interface acf_normalise_sequencer_if;
   import acf_pkg::*;

   logic        iStart;
   logic        oBusy;
   logic        oDone;
   logic        oOverrun;
   logic        oCoeffValid;
   lag_idx_t    oCoeffIndex;
   logic [31:0] oCoeff;

   modport master (
      input  iStart,
      output oBusy, oDone, oOverrun, oCoeffValid, oCoeffIndex, oCoeff
   );

   modport slave (
      output iStart,
      input  oBusy, oDone, oOverrun, oCoeffValid, oCoeffIndex, oCoeff
   );

endinterface

// File: rtl/acf_normalise_sequencer_tag_delay.sv
// -----------------------------------------------------------------------------
// acf_tag_delay
// Fixed-depth shift register carrying {valid, index, zero} tags in lock-step
// with the never-stalling converter/divider pipeline.
//   iClock       clock
//   iReset       synchronous active-high reset, clears every stage
//   tag_i        tag entering this cycle
//   tag_o        tag after DEPTH cycles
//   tap_valid_o  valid bit after TAP+1 cycles
//   tap_index_o  index after TAP+1 cycles
// -----------------------------------------------------------------------------
module acf_tag_delay
   import acf_pkg::*;
#(
   parameter int DEPTH = TAG_DEPTH,
   parameter int TAP   = 0
) (
   input  logic     iClock,
   input  logic     iReset,
   input  acf_tag_t tag_i,
   output acf_tag_t tag_o,
   output logic     tap_valid_o,
   output lag_idx_t tap_index_o
);

   acf_tag_t pipe_q [DEPTH];

   // NOTE: this array is deliberately reset: a surviving valid tag would emit a
   // stale coefficient after an abort. Plain storage arrays are not reset.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= tag_i;
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign tag_o       = pipe_q[DEPTH-1];
   assign tap_valid_o = pipe_q[TAP].valid;
   assign tap_index_o = pipe_q[TAP].index;

endmodule

// File: rtl/acf_normalise_sequencer.sv
// -----------------------------------------------------------------------------
// acf_normalise_sequencer
// Normalises one block of integer autocorrelation sums into IEEE single
// coefficients ACF[k]/ACF[0], k = 0..LAGS, time-sharing one int-to-float
// converter and one fp divider, and streams them out indexed by k.
//   iClock        clock
//   iReset        synchronous active-high reset, aborts a running block
//   ctrl          start/busy/done/overrun and coefficient stream (master)
//   oACFAddr      index of the integer sum being read
//   iACFData      signed sum at oACFAddr, combinational read
//   oConvEn       converter clk_en
//   oConvData     converter input, sign-extended sum
//   iConvResult   converter output
//   oDivEn        divider clk_en
//   oNumerator    divider dataa
//   oDenominator  divider datab (converted ACF[0], held for the block)
//   iDivResult    divider output
// Timing from the accepting cycle T: read k at T+1+k, converter input at
// T+2+k, divider inputs at T+3+k+CONV_DELAY, coefficient at
// T+4+k+CONV_DELAY+DIV_DELAY, oDone one cycle after the last coefficient.
// -----------------------------------------------------------------------------
module acf_normalise_sequencer
   import acf_pkg::*;
(
   input  logic                        iClock,
   input  logic                        iReset,
   acf_normalise_sequencer_if.master   ctrl,
   output lag_idx_t                    oACFAddr,
   input  logic [ACF_W-1:0]            iACFData,
   output logic                        oConvEn,
   output logic [63:0]                 oConvData,
   input  logic [31:0]                 iConvResult,
   output logic                        oDivEn,
   output logic [31:0]                 oNumerator,
   output logic [31:0]                 oDenominator,
   input  logic [31:0]                 iDivResult
);

   seq_state_t  state_q, state_d;
   logic        rd_act_q, rd_act_d;
   lag_idx_t    rd_addr_q, rd_addr_d;
   logic        zero_q, zero_d;

   logic [63:0] conv_data_q;
   logic [31:0] num_q;
   logic [31:0] den_q;
   logic        coeff_valid_q;
   lag_idx_t    coeff_idx_q;
   logic [31:0] coeff_q;

   logic        acf_zero;
   logic        tag_zero;
   acf_tag_t    tag_in;
   acf_tag_t    tag_out;
   logic        div_load;
   lag_idx_t    div_index;

   assign acf_zero = (iACFData == '0);

   // ACF[0] is judged live during its own read; later lags use the latched flag.
   assign tag_zero = (rd_addr_q == '0) ? acf_zero : zero_q;
   assign tag_in   = '{valid: rd_act_q, index: rd_addr_q, zero: tag_zero};

   // Tap at CONV_DELAY: tag for k is there exactly when iConvResult holds k.
   acf_tag_delay #(
      .DEPTH (TAG_DEPTH),
      .TAP   (CONV_DELAY)
   ) u_tag_delay (
      .iClock      (iClock),
      .iReset      (iReset),
      .tag_i       (tag_in),
      .tag_o       (tag_out),
      .tap_valid_o (div_load),
      .tap_index_o (div_index)
   );

   // NOTE: every variable driven here gets a default first, so no path through
   // the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      rd_act_d  = rd_act_q;
      rd_addr_d = rd_addr_q;
      zero_d    = zero_q;

      case (state_q)
         S_IDLE: begin
            if (ctrl.iStart) begin
               state_d   = S_RUN;
               rd_act_d  = 1'b1;
               rd_addr_d = '0;
               zero_d    = 1'b0;
            end
         end
         S_RUN: begin
            if (coeff_valid_q && (coeff_idx_q == LAST_IDX)) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Read window: one address per cycle, 0..LAGS, then stop.
      if (rd_act_q) begin
         if (rd_addr_q == LAST_IDX) begin
            rd_act_d  = 1'b0;
            rd_addr_d = '0;
         end else begin
            rd_addr_d = rd_addr_q + lag_idx_t'(1);
         end
         if (rd_addr_q == '0) zero_d = acf_zero;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q       <= S_IDLE;
         rd_act_q      <= 1'b0;
         rd_addr_q     <= '0;
         zero_q        <= 1'b0;
         conv_data_q   <= '0;
         num_q         <= '0;
         den_q         <= FP_ONE;
         coeff_valid_q <= 1'b0;
         coeff_idx_q   <= '0;
         coeff_q       <= '0;
      end else begin
         state_q   <= state_d;
         rd_act_q  <= rd_act_d;
         rd_addr_q <= rd_addr_d;
         zero_q    <= zero_d;

         if (rd_act_q) conv_data_q <= sext_acf(iACFData);

         // Lag 0 loads both operands; the denominator then holds for the block.
         if (div_load) begin
            num_q <= iConvResult;
            if (div_index == '0) den_q <= iConvResult;
         end

         // Index/value hold while no coefficient is being emitted.
         coeff_valid_q <= tag_out.valid;
         if (tag_out.valid) begin
            coeff_idx_q <= tag_out.index;
            if (tag_out.zero) begin
               // Zero ACF[0]: never pass the divider's NaN/Inf through.
               coeff_q <= (tag_out.index == '0) ? FP_ONE : 32'h0000_0000;
            end else begin
               coeff_q <= iDivResult;
            end
         end
      end
   end

   assign oACFAddr     = rd_act_q ? rd_addr_q : '0;
   assign oConvEn      = (state_q != S_IDLE);
   assign oDivEn       = (state_q != S_IDLE);
   assign oConvData    = conv_data_q;
   assign oNumerator   = num_q;
   assign oDenominator = den_q;

   assign ctrl.oBusy       = (state_q != S_IDLE);
   assign ctrl.oDone       = (state_q == S_DONE);
   assign ctrl.oOverrun    = ctrl.iStart && (state_q != S_IDLE);
   assign ctrl.oCoeffValid = coeff_valid_q;
   assign ctrl.oCoeffIndex = coeff_idx_q;
   assign ctrl.oCoeff      = coeff_q;

endmodule

// File: tb/tb_acf_normalise_sequencer.sv
// -----------------------------------------------------------------------------
// tb_acf_normalise_sequencer
// Bench for acf_normalise_sequencer with ideal converter/divider models and a
// scoreboard of expected coefficients and oDone cycles.
// -----------------------------------------------------------------------------
module tb_acf_normalise_sequencer;
   import acf_pkg::*;

   logic             iClock = 1'b0;
   logic             iReset;
   lag_idx_t         oACFAddr;
   logic [ACF_W-1:0] iACFData;
   logic             oConvEn;
   logic [63:0]      oConvData;
   logic [31:0]      iConvResult;
   logic             oDivEn;
   logic [31:0]      oNumerator;
   logic [31:0]      oDenominator;
   logic [31:0]      iDivResult;

   acf_normalise_sequencer_if bus ();

   acf_normalise_sequencer dut (
      .iClock       (iClock),
      .iReset       (iReset),
      .ctrl         (bus),
      .oACFAddr     (oACFAddr),
      .iACFData     (iACFData),
      .oConvEn      (oConvEn),
      .oConvData    (oConvData),
      .iConvResult  (iConvResult),
      .oDivEn       (oDivEn),
      .oNumerator   (oNumerator),
      .oDenominator (oDenominator),
      .iDivResult   (iDivResult)
   );

   always #5 iClock = ~iClock;

   int cyc = 0;
   always @(posedge iClock) cyc <= cyc + 1;

   int tests_run = 0;
   int failed    = 0;

   // ---------------- float helpers ----------------
   function automatic logic [31:0] real2sp(input real r);
      logic [63:0] b;
      int          e;
      if (r == 0.0) return 32'h0;
      b = $realtobits(r);
      e = int'(b[62:52]) - 1023 + 127;
      return {b[63], e[7:0], b[51:29]};
   endfunction

   function automatic real sp2real(input logic [31:0] s);
      logic [63:0] b;
      int          e;
      if (s[30:0] == 31'h0) return 0.0;
      e = int'(s[30:23]) - 127 + 1023;
      b = {s[31], e[10:0], s[22:0], 29'd0};
      return $bitstoreal(b);
   endfunction

   // ---------------- sums memory ----------------
   logic [ACF_W-1:0] acf_mem [16];
   assign iACFData = acf_mem[oACFAddr];

   // ---------------- converter model ----------------
   logic [31:0] conv_pipe [CONV_DELAY];
   initial for (int i = 0; i < CONV_DELAY; i++) conv_pipe[i] = '0;
   always @(posedge iClock) begin
      if (oConvEn) begin
         conv_pipe[0] <= real2sp(real'($signed(oConvData)));
         for (int i = 1; i < CONV_DELAY; i++) conv_pipe[i] <= conv_pipe[i-1];
      end
   end
   assign iConvResult = conv_pipe[CONV_DELAY-1];

   // ---------------- divider model (NaN on zero divisor) ----------------
   logic [31:0] div_pipe [DIV_DELAY];
   initial for (int i = 0; i < DIV_DELAY; i++) div_pipe[i] = '0;
   always @(posedge iClock) begin
      if (oDivEn) begin
         if (oDenominator[30:0] == 31'h0) div_pipe[0] <= 32'h7FC0_0000;
         else div_pipe[0] <= real2sp(sp2real(oNumerator) / sp2real(oDenominator));
         for (int i = 1; i < DIV_DELAY; i++) div_pipe[i] <= div_pipe[i-1];
      end
   end
   assign iDivResult = div_pipe[DIV_DELAY-1];

   // ---------------- scoreboard ----------------
   typedef struct {
      int          at;
      lag_idx_t    idx;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q  [$];
   int   done_q [$];

   always @(negedge iClock) begin
      if (bus.oCoeffValid) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL coeff_unexpected cyc=%0d idx=%0d val=%h required=no coefficient",
                     cyc, bus.oCoeffIndex, bus.oCoeff);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (cyc !== e.at || bus.oCoeffIndex !== e.idx || bus.oCoeff !== e.val) begin
               failed++;
               $display("FAIL coeff cyc=%0d idx=%0d val=%h required cyc=%0d idx=%0d val=%h",
                        cyc, bus.oCoeffIndex, bus.oCoeff, e.at, e.idx, e.val);
            end
         end
      end
      if (bus.oDone) begin
         tests_run++;
         if (done_q.size() == 0) begin
            failed++;
            $display("FAIL done_unexpected cyc=%0d required=no oDone", cyc);
         end else begin
            int d;
            d = done_q.pop_front();
            if (cyc !== d) begin
               failed++;
               $display("FAIL done_cycle cyc=%0d required=%0d", cyc, d);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic goto_cycle(input int c);
      if (cyc > c) begin
         failed++;
         $display("FAIL goto_cycle cyc=%0d required<=%0d", cyc, c);
      end
      while (cyc < c) begin
         @(posedge iClock);
         #1;
      end
   endtask

   // Expected results of a block started at T, computed from acf_mem.
   task automatic push_block(input int t);
      exp_t e;
      for (int k = 0; k <= LAGS; k++) begin
         e.at  = t + 4 + k + CONV_DELAY + DIV_DELAY;
         e.idx = lag_idx_t'(k);
         if (acf_mem[0] == '0)
            e.val = (k == 0) ? FP_ONE : 32'h0;
         else
            e.val = real2sp(real'($signed(acf_mem[k])) / real'($signed(acf_mem[0])));
         exp_q.push_back(e);
      end
      done_q.push_back(t + 5 + LAGS + CONV_DELAY + DIV_DELAY);
   endtask

   task automatic pulse_start(input int t);
      goto_cycle(t);
      bus.iStart = 1'b1;
      goto_cycle(t + 1);
      bus.iStart = 1'b0;
   endtask

   task automatic check_drained(input string name);
      tests_run++;
      if (exp_q.size() != 0 || done_q.size() != 0) begin
         failed++;
         $display("FAIL %s_drained pending_coeffs=%0d pending_done=%0d required=0/0",
                  name, exp_q.size(), done_q.size());
         exp_q.delete();
         done_q.delete();
      end
   endtask

   task automatic check_reset_outputs(input string name);
      logic [173:0] got, req;
      @(negedge iClock);
      got = {oACFAddr, oConvEn, oConvData, oDivEn, oNumerator, oDenominator,
             bus.oCoeffValid, bus.oCoeffIndex, bus.oCoeff, bus.oBusy, bus.oDone, bus.oOverrun};
      req = {4'd0, 1'b0, 64'd0, 1'b0, 32'd0, FP_ONE, 1'b0, 4'd0, 32'd0, 3'b000};
      tests_run++;
      if (got !== req) begin
         failed++;
         $display("FAIL %s outputs=%h required=%h", name, got, req);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      iReset     = 1'b1;
      bus.iStart = 1'b0;
      for (int k = 0; k < 16; k++) acf_mem[k] = '0;
      repeat (3) @(posedge iClock);
      #1;
      check_reset_outputs("reset_state");
      @(posedge iClock);
      #1;
      iReset = 1'b0;
   endtask

   // Ramp block with the enable and read-address schedule checked every cycle.
   task automatic test_ramp();
      int t;
      logic       en_req;
      lag_idx_t   addr_req;
      t = cyc + 2;
      for (int k = 0; k <= LAGS; k++) acf_mem[k] = ACF_W'(4096 - 256 * k);
      push_block(t);
      exp_q[0].val  = 32'h3F80_0000;   // 1.0
      exp_q[1].val  = 32'h3F70_0000;   // 0.9375
      exp_q[12].val = 32'h3E80_0000;   // 0.25
      for (int c = 0; c <= 40; c++) begin
         goto_cycle(t + c);
         bus.iStart = (c == 0);
         @(negedge iClock);
         en_req   = (c >= 1 && c <= 38);
         addr_req = (c >= 1 && c <= 13) ? lag_idx_t'(c - 1) : lag_idx_t'(0);
         tests_run++;
         if ({oConvEn, oDivEn, bus.oBusy, oACFAddr} !== {en_req, en_req, en_req, addr_req}) begin
            failed++;
            $display("FAIL ramp_schedule T+%0d conv_en=%b div_en=%b busy=%b addr=%0d required en=%b addr=%0d",
                     c, oConvEn, oDivEn, bus.oBusy, oACFAddr, en_req, addr_req);
         end
      end
      goto_cycle(t + 45);
      check_drained("ramp");
   endtask

   task automatic test_zero_acf0();
      int t;
      t = cyc + 2;
      for (int k = 0; k <= LAGS; k++) acf_mem[k] = '0;
      push_block(t);
      pulse_start(t);
      goto_cycle(t + 45);
      check_drained("zero_acf0");
   endtask

   task automatic test_negative_lag();
      int t;
      t = cyc + 2;
      acf_mem[0] = ACF_W'(1000);
      acf_mem[1] = ACF_W'(-500);
      for (int k = 2; k <= LAGS; k++) acf_mem[k] = ACF_W'(-250 * k + 1000);
      push_block(t);
      exp_q[1].val = 32'hBF00_0000;   // -0.5
      pulse_start(t);
      goto_cycle(t + 3);
      @(negedge iClock);
      tests_run++;
      if (oConvData !== 64'hFFFF_FFFF_FFFF_FE0C) begin
         failed++;
         $display("FAIL neg_conv_data got=%h required=%h", oConvData, 64'hFFFF_FFFF_FFFF_FE0C);
      end
      goto_cycle(t + 45);
      check_drained("negative_lag");
   endtask

   task automatic test_back_to_back();
      int t;
      t = cyc + 2;
      for (int k = 0; k <= LAGS; k++) acf_mem[k] = ACF_W'(2048 - 128 * k);
      push_block(t);
      pulse_start(t);
      goto_cycle(t + 10);
      bus.iStart = 1'b1;
      @(negedge iClock);
      tests_run++;
      if (bus.oOverrun !== 1'b1) begin
         failed++;
         $display("FAIL overrun_busy got=%b required=1", bus.oOverrun);
      end
      goto_cycle(t + 11);
      bus.iStart = 1'b0;
      @(negedge iClock);
      tests_run++;
      if (bus.oOverrun !== 1'b0) begin
         failed++;
         $display("FAIL overrun_clear got=%b required=0", bus.oOverrun);
      end
      goto_cycle(t + 38);
      push_block(t + 39);
      goto_cycle(t + 39);
      bus.iStart = 1'b1;
      @(negedge iClock);
      tests_run++;
      if (bus.oOverrun !== 1'b0 || bus.oBusy !== 1'b0) begin
         failed++;
         $display("FAIL restart_idle overrun=%b busy=%b required overrun=0 busy=0",
                  bus.oOverrun, bus.oBusy);
      end
      goto_cycle(t + 40);
      bus.iStart = 1'b0;
      goto_cycle(t + 85);
      check_drained("back_to_back");
   endtask

   task automatic test_reset_mid_run();
      int t;
      t = cyc + 2;
      for (int k = 0; k <= LAGS; k++) acf_mem[k] = ACF_W'(3000 - 200 * k);
      pulse_start(t);
      goto_cycle(t + 20);
      iReset = 1'b1;
      goto_cycle(t + 21);
      iReset = 1'b0;
      check_reset_outputs("reset_mid_run");
      goto_cycle(t + 50);
      check_drained("reset_abort");
      // A fresh block after the abort must complete normally.
      t = cyc + 2;
      for (int k = 0; k <= LAGS; k++) acf_mem[k] = ACF_W'(512 - 32 * k);
      push_block(t);
      pulse_start(t);
      goto_cycle(t + 45);
      check_drained("after_reset");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d required=completion", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_ramp();
      test_zero_acf0();
      test_negative_lag();
      test_back_to_back();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
